// File: rtl/p4_ing_policer.sv
// p4_ing_policer: per-queue leaky-bucket ingress policer that marks (never drops) over-rate packets; ING_POLICER_DROP_COUNTERS_EN adds per-queue drop counters.
// Latency: 1 cycle through a single output register; counter reads answer 1 cycle after cnt_rd_en.
// Backpressure: s_tready = !m_tvalid || m_tready; buckets keep draining while the stage is stalled.
package p4_ing_policer_pkg;
    localparam int NUM_QSYS_TABLES_LOG = 2;
    localparam logic [NUM_QSYS_TABLES_LOG-1:0] ING_POLICER_CIR_TABLE = 2'd0;
    localparam logic [NUM_QSYS_TABLES_LOG-1:0] ING_POLICER_CBS_TABLE = 2'd1;
    localparam int QSYS_TABLE_DATALEN = 32;
    localparam int QSYS_COUNTER_WIDTH = 32;

    typedef struct packed {
        logic [7:0]  user_tag;
        logic [2:0]  prio;
        logic [2:0]  egress_port;
        logic [15:0] byte_length;
    } vnp4_wrapper_metadata_t;

    typedef struct packed {
        logic                   policer_drop_mark;
        vnp4_wrapper_metadata_t wrapper;
    } policer_metadata_t;

    localparam int VNP4_WRAPPER_METADATA_WIDTH = $bits(vnp4_wrapper_metadata_t);
    localparam int POLICER_METADATA_WIDTH      = $bits(policer_metadata_t);

    // Bucket fill level in bytes, 20.13 fixed point; CIR drain per clock is 3.13.
    typedef struct packed {
        logic [19:0] whole;
        logic [12:0] frac;
    } bucket_t;
    typedef logic [15:0] bucket_decrement_t;

    function automatic policer_metadata_t add_policer_drop_mark_to_metadata(
        input logic mark, input vnp4_wrapper_metadata_t md);
        policer_metadata_t r;
        r.policer_drop_mark = mark;
        r.wrapper           = md;
        return r;
    endfunction
endpackage

module p4_ing_policer
    import p4_ing_policer_pkg::*;
#(
    parameter int DATA_BYTES              = 8,
    parameter int NUM_EGR_PORTS           = 4,
    parameter int NUM_QUEUES_PER_EGR_PORT = 4,
    parameter int NUM_QUEUES              = NUM_EGR_PORTS*NUM_QUEUES_PER_EGR_PORT
) (
    input  logic                                   clk,
    input  logic                                   aresetn,
    input  logic [8*DATA_BYTES-1:0]                s_tdata,
    input  logic [DATA_BYTES-1:0]                  s_tkeep,
    input  logic                                   s_tlast,
    input  logic [VNP4_WRAPPER_METADATA_WIDTH-1:0] s_tuser,
    input  logic                                   s_tvalid,
    output logic                                   s_tready,
    output logic [8*DATA_BYTES-1:0]                m_tdata,
    output logic [DATA_BYTES-1:0]                  m_tkeep,
    output logic                                   m_tlast,
    output logic [POLICER_METADATA_WIDTH-1:0]      m_tuser,
    output logic                                   m_tvalid,
    input  logic                                   m_tready,
    input  logic                                   cfg_wr_en,
    input  logic [NUM_QSYS_TABLES_LOG-1:0]         cfg_select,
    input  logic [$clog2(NUM_QUEUES)-1:0]          cfg_addr,
    input  logic [QSYS_TABLE_DATALEN-1:0]          cfg_wr_data,
    input  logic                                   cnt_rd_en,
    input  logic                                   cnt_rd_clear,
    input  logic [$clog2(NUM_QUEUES)-1:0]          cnt_rd_queue,
    output logic [QSYS_COUNTER_WIDTH-1:0]          cnt_rd_data,
    output logic                                   cnt_rd_valid
);
    localparam int QW = $clog2(NUM_QUEUES);

    bucket_t           r_bucket [NUM_QUEUES];
    bucket_decrement_t r_cir    [NUM_QUEUES];
    logic [19:0]       r_cbs    [NUM_QUEUES];

    logic              r_sop;
    logic              r_mark;
    logic [8*DATA_BYTES-1:0] r_m_tdata;
    logic [DATA_BYTES-1:0]   r_m_tkeep;
    logic                    r_m_tlast;
    policer_metadata_t       r_m_tuser;
    logic                    r_m_tvalid;
    logic                    r_cnt_rd_valid;

    vnp4_wrapper_metadata_t w_in_md;
    logic [QW-1:0]     w_q;
    logic              w_port_ok;
    logic              w_xfer;
    logic              w_sop_xfer;
    bucket_t           w_b_cur;
    logic [19:0]       w_thr;
    logic              w_over;
    logic              w_dec_mark;
    logic              w_dec_charge;
    logic              w_charge;
    logic              w_mark;
    logic              w_cir_wr;
    logic              w_cbs_wr;
    bucket_t           w_drained [NUM_QUEUES];
    logic [33:0]       w_sum;
    bucket_t           w_charged;
    logic              w_unused_cfg;

    assign w_in_md    = s_tuser;
    assign w_port_ok  = int'(w_in_md.egress_port) < NUM_EGR_PORTS;
    assign w_q        = QW'(w_in_md.egress_port) * QW'(NUM_QUEUES_PER_EGR_PORT)
                      + QW'(w_in_md.prio & 3'(NUM_QUEUES_PER_EGR_PORT-1));
    assign s_tready   = !r_m_tvalid || m_tready;
    assign w_xfer     = s_tvalid && s_tready;
    assign w_sop_xfer = w_xfer && r_sop;

    assign w_b_cur = r_bucket[w_q];
    assign w_thr   = r_cbs[w_q];
    assign w_over  = ({1'b0, w_b_cur.whole} + {5'b0, w_in_md.byte_length}) > {1'b0, w_thr};

    always_comb begin
        w_dec_mark   = 1'b0;
        w_dec_charge = 1'b0;
        if (!w_port_ok) begin
            w_dec_mark = 1'b1;
        end else if (w_thr != '0) begin
            if (w_over) w_dec_mark   = 1'b1;
            else        w_dec_charge = 1'b1;
        end
    end

    assign w_charge = w_sop_xfer && w_dec_charge;
    assign w_mark   = r_sop ? w_dec_mark : r_mark;

    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            w_drained[i] = (r_bucket[i] > 33'(r_cir[i])) ? r_bucket[i] - 33'(r_cir[i]) : '0;
        end
    end

    // Adding whole bytes never touches the fraction; overflow pins the whole part.
    assign w_sum     = {1'b0, w_drained[w_q]} + {5'b0, w_in_md.byte_length, 13'b0};
    assign w_charged = w_sum[33] ? {20'hFFFFF, w_sum[12:0]} : w_sum[32:0];

    assign w_cir_wr     = cfg_wr_en && (cfg_select == ING_POLICER_CIR_TABLE);
    assign w_cbs_wr     = cfg_wr_en && (cfg_select == ING_POLICER_CBS_TABLE);
    assign w_unused_cfg = ^cfg_wr_data[QSYS_TABLE_DATALEN-1:20];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                r_bucket[i] <= '0;
                r_cir[i]    <= '0;
                r_cbs[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (w_cir_wr && cfg_addr == QW'(i)) r_cir[i] <= cfg_wr_data[15:0];
                if (w_cbs_wr && cfg_addr == QW'(i)) r_cbs[i] <= cfg_wr_data[19:0];
                if (w_cbs_wr && cfg_addr == QW'(i))
                    r_bucket[i] <= '0;
                else if (w_charge && w_q == QW'(i))
                    r_bucket[i] <= w_charged;
                else
                    r_bucket[i] <= w_drained[i];
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sop      <= 1'b1;
            r_mark     <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
            r_m_tvalid <= 1'b0;
        end else if (w_xfer) begin
            r_sop      <= s_tlast;
            r_mark     <= w_mark;
            r_m_tdata  <= s_tdata;
            r_m_tkeep  <= s_tkeep;
            r_m_tlast  <= s_tlast;
            r_m_tuser  <= add_policer_drop_mark_to_metadata(w_mark, w_in_md);
            r_m_tvalid <= 1'b1;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tkeep  = r_m_tkeep;
    assign m_tlast  = r_m_tlast;
    assign m_tuser  = r_m_tuser;
    assign m_tvalid = r_m_tvalid;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_cnt_rd_valid <= 1'b0;
        else          r_cnt_rd_valid <= cnt_rd_en;
    end
    assign cnt_rd_valid = r_cnt_rd_valid;

`ifdef ING_POLICER_DROP_COUNTERS_EN
    logic [QSYS_COUNTER_WIDTH-1:0] r_cnt [NUM_QUEUES];
    logic [QSYS_COUNTER_WIDTH-1:0] r_cnt_rd_data;
    logic [QW-1:0]                 w_cnt_q;
    logic                          w_cnt_inc;

    // Out-of-range egress ports are accounted against the last queue.
    assign w_cnt_q   = w_port_ok ? w_q : QW'(NUM_QUEUES-1);
    assign w_cnt_inc = w_sop_xfer && w_dec_mark;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_QUEUES; i++) r_cnt[i] <= '0;
            r_cnt_rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (cnt_rd_en && cnt_rd_clear && cnt_rd_queue == QW'(i))
                    r_cnt[i] <= (w_cnt_inc && w_cnt_q == QW'(i)) ? QSYS_COUNTER_WIDTH'(1) : '0;
                else if (w_cnt_inc && w_cnt_q == QW'(i) && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            if (cnt_rd_en) r_cnt_rd_data <= r_cnt[cnt_rd_queue];
        end
    end
    assign cnt_rd_data = r_cnt_rd_data;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^{cnt_rd_clear, cnt_rd_queue};
    assign cnt_rd_data  = '0;
`endif
endmodule

// File: tb/tb_p4_ing_policer.sv
// Bench for p4_ing_policer: vector table of single-beat packets plus hand-written multi-beat, stall, counter and reset sequences.
// Output beats are checked against a scoreboard queue filled as stimulus is accepted.
module tb_p4_ing_policer;
    import p4_ing_policer_pkg::*;

`ifdef ING_POLICER_DROP_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aresetn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic [VNP4_WRAPPER_METADATA_WIDTH-1:0] s_tuser;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic [POLICER_METADATA_WIDTH-1:0] m_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic        cfg_wr_en;
    logic [NUM_QSYS_TABLES_LOG-1:0] cfg_select;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wr_data;
    logic        cnt_rd_en;
    logic        cnt_rd_clear;
    logic [3:0]  cnt_rd_queue;
    logic [31:0] cnt_rd_data;
    logic        cnt_rd_valid;

    always #5 clk = ~clk;

    p4_ing_policer #(
        .DATA_BYTES(8), .NUM_EGR_PORTS(4), .NUM_QUEUES_PER_EGR_PORT(4)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .cfg_wr_en(cfg_wr_en), .cfg_select(cfg_select), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
        .cnt_rd_en(cnt_rd_en), .cnt_rd_clear(cnt_rd_clear), .cnt_rd_queue(cnt_rd_queue),
        .cnt_rd_data(cnt_rd_data), .cnt_rd_valid(cnt_rd_valid)
    );

    typedef struct {
        bit          do_cfg;
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [31:0] cdata;
        logic [2:0]  port;
        logic [2:0]  prio;
        logic [15:0] len;
        int          idle;
        bit          exp_mark;
    } vec_t;

    typedef struct packed {
        logic [63:0]       d;
        logic [7:0]        k;
        logic              l;
        policer_metadata_t u;
    } beat_t;

    beat_t sb_q[$];
    vec_t  vt[$];
    int    exp_cnt[16];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    tready_mode = 0;   // 0: always ready, 1: toggle each cycle, 2: held low

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit c, input logic [1:0] sel, input logic [3:0] a,
                                input logic [31:0] cd, input logic [2:0] port, input logic [2:0] prio,
                                input logic [15:0] len, input int idle, input bit m);
        vec_t v;
        v.do_cfg = c; v.sel = sel; v.addr = a; v.cdata = cd;
        v.port = port; v.prio = prio; v.len = len; v.idle = idle; v.exp_mark = m;
        return v;
    endfunction

    function automatic vnp4_wrapper_metadata_t mkmd(input logic [2:0] port, input logic [2:0] prio,
                                                    input logic [15:0] len, input logic [7:0] tag);
        vnp4_wrapper_metadata_t md;
        md.user_tag = tag; md.prio = prio; md.egress_port = port; md.byte_length = len;
        return md;
    endfunction

    function automatic int qidx(input logic [2:0] port, input logic [2:0] prio);
        if (port >= 3'd4) return 15;
        return int'(port) * 4 + int'(prio[1:0]);
    endfunction

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (aresetn && m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got tdata %0h with no beat expected", m_tdata);
                end else begin
                    e = sb_q.pop_front();
                    check("out_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input vnp4_wrapper_metadata_t md, input logic exp_mark);
        int  waited = 0;
        bit  ok = 1'b0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = md; s_tvalid = 1'b1;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (s_tready) ok = 1'b1;
            else waited++;
        end
        if (ok) sb_q.push_back({d, k, l, add_policer_drop_mark_to_metadata(exp_mark, md)});
        else begin
            n_checks++;
            $display("FAIL send_timeout: s_tready stayed 0, required 1");
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [3:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_select = sel; cfg_addr = a; cfg_wr_data = d;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic cnt_read(input logic [3:0] q, input logic clr, input logic [31:0] exp, input string name);
        cnt_rd_en = 1'b1; cnt_rd_queue = q; cnt_rd_clear = clr;
        @(posedge clk); #1;
        cnt_rd_en = 1'b0; cnt_rd_clear = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, cnt_rd_valid, 1);
        check(name, cnt_rd_data, exp);
        @(negedge clk);
        check({name, "_valid_pulse"}, cnt_rd_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vnp4_wrapper_metadata_t md;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
        cfg_wr_en = 1'b0; cfg_select = '0; cfg_addr = '0; cfg_wr_data = '0;
        cnt_rd_en = 1'b0; cnt_rd_clear = 1'b0; cnt_rd_queue = '0;
        for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
        aresetn = 1'b0;

        // Unpoliced traffic, an out-of-range port, then CBS=100/CIR=0 and CIR=1.0 B/clk on queue 0.
        for (int i = 0; i < 10; i++) vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 16'd64, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3'd1, 3'd2, 16'd200, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3'd7, 3'd0, 16'd64, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 3'd3, 3'd3, 16'd1500, 0, 0));
        vt.push_back(mk(1, ING_POLICER_CBS_TABLE, 4'd0, 32'd100, 3'd0, 3'd0, 16'd64, 0, 0));
        vt.push_back(mk(1, ING_POLICER_CIR_TABLE, 4'd0, 32'd0, 3'd0, 3'd0, 16'd64, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 16'd36, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 16'd1, 0, 1));
        vt.push_back(mk(1, ING_POLICER_CBS_TABLE, 4'd0, 32'd100, 3'd0, 3'd0, 16'd100, 0, 0));
        vt.push_back(mk(1, ING_POLICER_CIR_TABLE, 4'd0, 32'h2000, 3'd0, 3'd3, 16'd10, 120, 0));
        vt.push_back(mk(1, ING_POLICER_CBS_TABLE, 4'd0, 32'd100, 3'd0, 3'd0, 16'd64, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 16'd64, 64, 1));
        vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 16'd64, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 16'd36, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd0, 16'd2, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 3'd0, 3'd4, 16'd3, 0, 1));

        #2;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_cnt_rd_valid", cnt_rd_valid, 0);
        check("rst_cnt_rd_data", cnt_rd_data, 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            if (vt[i].do_cfg) cfg_write(vt[i].sel, vt[i].addr, vt[i].cdata);
            md = mkmd(vt[i].port, vt[i].prio, vt[i].len, 8'(i));
            send_beat({$urandom, $urandom}, 8'hFF, 1'b1, md, vt[i].exp_mark);
            if (vt[i].exp_mark) exp_cnt[qidx(vt[i].port, vt[i].prio)]++;
            idle(vt[i].idle);
        end

        // Mark latched at SOP across beats whose tuser changes, under a toggling m_tready.
        cfg_write(ING_POLICER_CBS_TABLE, 4'd1, 32'd10);
        tready_mode = 1;
        send_beat(64'h1111_0000_0000_0001, 8'hFF, 1'b0, mkmd(3'd0, 3'd1, 16'd20, 8'hA0), 1'b1);
        send_beat(64'h1111_0000_0000_0002, 8'hFF, 1'b0, mkmd(3'd0, 3'd2, 16'd0, 8'hA1), 1'b1);
        send_beat(64'h1111_0000_0000_0003, 8'h0F, 1'b1, mkmd(3'd1, 3'd1, 16'd0, 8'hA2), 1'b1);
        exp_cnt[1]++;
        send_beat(64'h2222_0000_0000_0001, 8'hFF, 1'b0, mkmd(3'd0, 3'd1, 16'd5, 8'hB0), 1'b0);
        send_beat(64'h2222_0000_0000_0002, 8'hFF, 1'b0, mkmd(3'd0, 3'd1, 16'd100, 8'hB1), 1'b0);
        send_beat(64'h2222_0000_0000_0003, 8'h03, 1'b1, mkmd(3'd7, 3'd0, 16'd100, 8'hB2), 1'b0);
        tready_mode = 0;
        idle(4);

        // CBS write in the same cycle as an SOP: that SOP still sees the old (unpoliced) threshold.
        cfg_wr_en = 1'b1; cfg_select = ING_POLICER_CBS_TABLE; cfg_addr = 4'd3; cfg_wr_data = 32'd10;
        send_beat(64'h3333_0000_0000_0001, 8'hFF, 1'b1, mkmd(3'd0, 3'd3, 16'd50, 8'hC0), 1'b0);
        cfg_wr_en = 1'b0;
        send_beat(64'h3333_0000_0000_0002, 8'hFF, 1'b1, mkmd(3'd0, 3'd3, 16'd50, 8'hC1), 1'b1);
        exp_cnt[3]++;

        cnt_read(4'd15, 1'b0, CNT_EN ? 32'(exp_cnt[15]) : 32'd0, "cnt_q15");
        cnt_read(4'd15, 1'b1, CNT_EN ? 32'(exp_cnt[15]) : 32'd0, "cnt_q15_clr");
        exp_cnt[15] = 0;
        cnt_read(4'd15, 1'b0, 32'd0, "cnt_q15_after_clr");
        cnt_read(4'd0, 1'b0, CNT_EN ? 32'(exp_cnt[0]) : 32'd0, "cnt_q0");
        cnt_read(4'd1, 1'b0, CNT_EN ? 32'(exp_cnt[1]) : 32'd0, "cnt_q1");

        // Clear-on-read colliding with a marked SOP on the same queue leaves the counter at 1.
        cnt_rd_en = 1'b1; cnt_rd_queue = 4'd3; cnt_rd_clear = 1'b1;
        send_beat(64'h4444_0000_0000_0001, 8'hFF, 1'b1, mkmd(3'd0, 3'd3, 16'd50, 8'hD0), 1'b1);
        cnt_rd_en = 1'b0; cnt_rd_clear = 1'b0;
        @(negedge clk);
        check("cnt_q3_clr_valid", cnt_rd_valid, 1);
        check("cnt_q3_clr", cnt_rd_data, CNT_EN ? 32'(exp_cnt[3]) : 32'd0);
        @(posedge clk); #1;
        exp_cnt[3] = 1;
        cnt_read(4'd3, 1'b0, CNT_EN ? 32'(exp_cnt[3]) : 32'd0, "cnt_q3_clr_inc");

        // Reset mid-packet while the output is stalled.
        cfg_write(ING_POLICER_CBS_TABLE, 4'd2, 32'd1);
        tready_mode = 2;
        send_beat(64'h5555_0000_0000_0001, 8'hFF, 1'b0, mkmd(3'd0, 3'd2, 16'd64, 8'hE0), 1'b1);
        idle(1);
        check("stall_hold_valid", m_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_s_tready", s_tready, 1);
        sb_q.delete();
        for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        tready_mode = 0;
        send_beat(64'h5555_0000_0000_0002, 8'hFF, 1'b1, mkmd(3'd0, 3'd2, 16'd64, 8'hE1), 1'b0);
        send_beat(64'h6666_0000_0000_0001, 8'hFF, 1'b1, mkmd(3'd0, 3'd0, 16'd200, 8'hE2), 1'b0);
        send_beat(64'h6666_0000_0000_0002, 8'hFF, 1'b1, mkmd(3'd0, 3'd0, 16'd200, 8'hE3), 1'b0);
        cnt_read(4'd0, 1'b0, 32'd0, "cnt_q0_after_rst");

        idle(10);
        check("sb_empty", 128'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
